ldpc_ber_run_sequencer: RTL
===========================

Name: ldpc_ber_run_sequencer

Overview:
- Sequences one BER test run on the LDPC BER tester.
- Issues CTRL beats to the LDPC core until a programmed block count is reached, capping outstanding blocks at a credit window.
- Drains outstanding blocks, then reports done, run statistics and a watchdog timeout.
- Sits between the register map (start/abort/config) and the core's CTRL and DOUT-finish signals.

Parameters:
CNT_WIDTH, 64, width of issued/completed/run_cycles counters
CREDIT_WIDTH, 8, width of max_in_flight and in_flight
TO_WIDTH, 32, width of watchdog timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  pulse; begins run when idle/done
abort  in  1  pulse; stop issuing, drain
target_blocks  in  CNT_WIDTH  blocks to issue this run
max_in_flight  in  CREDIT_WIDTH  credit window; 0 treated as 1
timeout_cycles  in  TO_WIDTH  watchdog limit; 0 disables
ctrl_valid  out  1  CTRL beat valid to LDPC core
ctrl_ready  in  1  CTRL beat ready from core
dout_finish  in  1  last DOUT beat transferred (valid&ready&last)
busy  out  1  state is RUN or DRAIN
done  out  1  state is DONE
timeout_err  out  1  sticky; run ended by watchdog
underflow_err  out  1  sticky; dout_finish with in_flight==0
issued_blocks  out  CNT_WIDTH  CTRL handshakes this run
completed_blocks  out  CNT_WIDTH  dout_finish pulses this run
in_flight  out  CREDIT_WIDTH  outstanding blocks
run_cycles  out  CNT_WIDTH  cycles spent busy, saturating

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0.
- States: IDLE, RUN, DRAIN, DONE. All outputs are registered.
- IDLE/DONE + start:
  - latch target, limit (max(max_in_flight,1)) and timeout;
  - clear counters, done, timeout_err and underflow_err;
  - go to RUN. If target_blocks==0, go directly to DONE.
- start while busy: ignored. abort in IDLE/DONE: ignored.
- Handshake hs = ctrl_valid & ctrl_ready:
  - issued+1, in_flight+1.
- dout_finish:
  - completed+1 and in_flight-1;
  - if in_flight==0: in_flight stays 0 and underflow_err is set (completed still increments).
- hs & dout_finish in same cycle: in_flight unchanged; both counters increment.
- ctrl_valid next = (ctrl_valid & !ctrl_ready) | (state_next==RUN & issued_next<target & in_flight_next<limit).
  - Uses post-update values, so back-to-back beats are possible.
  - First ctrl_valid is one cycle after busy rises.
  - ctrl_valid never drops without a handshake, except on watchdog expiry or reset.
- RUN -> DRAIN when issued_next==target, or on abort.
  - A beat pending at abort stays valid until accepted and is counted.
- DRAIN -> DONE when in_flight_next==0 and ctrl_valid_next==0.
- Watchdog:
  - counter clears on hs, dout_finish or entering RUN; increments while busy;
  - if timeout≠0 and counter reaches timeout: timeout_err=1, ctrl_valid=0, state DONE next cycle;
  - in_flight retains its value.
- run_cycles increments each busy cycle and saturates at all-ones.
- Counters hold their values in DONE until the next start.

Test Plan:
- target=5, limit=2, ctrl_ready=1, dout_finish 3 cycles after each hs -> in_flight ≤2 throughout; issued=completed=5; done=1; busy=0; timeout_err=0.
- target=3, limit=4, ctrl_ready held low 4 cycles after first valid -> ctrl_valid stays high continuously; issued increments only on ready; final issued=3.
- hs and dout_finish in same cycle with in_flight=1 -> in_flight stays 1; issued and completed both +1.
- target=10, abort after issued=3 with beat pending -> pending beat accepted (issued=4), no further valid; DRAIN until in_flight=0; done=1.
- timeout=100, limit=1, no dout_finish -> after first hs, timeout_err=1 at watchdog count 100; ctrl_valid=0; done=1; in_flight=1.
- target=0 start -> done=1 next cycle, ctrl_valid never high. Separately, reset asserted mid-RUN -> all outputs 0 immediately; restart works. dout_finish in IDLE -> underflow_err=1, in_flight=0.

Source files
------------

// File: rtl/ldpc_ber_run_sequencer.sv
// ldpc_ber_run_sequencer: sequences one BER test run on the LDPC tester.
// It issues CTRL beats under a credit window, drains outstanding blocks,
// and then reports completion, run statistics and a watchdog timeout.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, abort      run control pulses from the register map
//   target_blocks     number of blocks to issue in this run
//   max_in_flight     credit window (0 behaves as 1)
//   timeout_cycles    watchdog limit (0 disables the watchdog)
//   ctrl_valid/ready  CTRL beat handshake with the LDPC core
//   dout_finish       last DOUT beat of a block transferred
//   busy, done        run status (RUN/DRAIN, DONE)
//   timeout_err       sticky, run ended by the watchdog
//   underflow_err     sticky, dout_finish seen with nothing in flight
//   issued_blocks     CTRL handshakes in this run
//   completed_blocks  dout_finish pulses in this run
//   in_flight         outstanding blocks
//   run_cycles        busy cycles, saturating
module ldpc_ber_run_sequencer #(
    parameter int CNT_WIDTH    = 64,
    parameter int CREDIT_WIDTH = 8,
    parameter int TO_WIDTH     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_WIDTH-1:0]    target_blocks,
    input  logic [CREDIT_WIDTH-1:0] max_in_flight,
    input  logic [TO_WIDTH-1:0]     timeout_cycles,
    output logic                    ctrl_valid,
    input  logic                    ctrl_ready,
    input  logic                    dout_finish,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic                    underflow_err,
    output logic [CNT_WIDTH-1:0]    issued_blocks,
    output logic [CNT_WIDTH-1:0]    completed_blocks,
    output logic [CREDIT_WIDTH-1:0] in_flight,
    output logic [CNT_WIDTH-1:0]    run_cycles
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CNT_WIDTH-1:0]    CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CREDIT_WIDTH-1:0] CR_ONE  = CREDIT_WIDTH'(1);
    localparam logic [TO_WIDTH-1:0]     TO_ONE  = TO_WIDTH'(1);

    logic [1:0]              state_q;
    logic [1:0]              state_d;
    logic [CNT_WIDTH-1:0]    target_q;
    logic [CNT_WIDTH-1:0]    target_d;
    logic [CREDIT_WIDTH-1:0] limit_q;
    logic [CREDIT_WIDTH-1:0] limit_d;
    logic [TO_WIDTH-1:0]     timeout_q;
    logic [TO_WIDTH-1:0]     timeout_d;
    logic [TO_WIDTH-1:0]     wd_q;
    logic [TO_WIDTH-1:0]     wd_d;

    logic                    cv_d;
    logic                    busy_d;
    logic                    done_d;
    logic                    terr_d;
    logic                    uerr_d;
    logic [CNT_WIDTH-1:0]    issued_d;
    logic [CNT_WIDTH-1:0]    completed_d;
    logic [CREDIT_WIDTH-1:0] inflight_d;
    logic [CNT_WIDTH-1:0]    cycles_d;

    logic hs;
    logic is_busy;
    logic pending;
    logic expire;
    logic can_issue;

    always_comb begin
        hs      = ctrl_valid & ctrl_ready;
        is_busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        pending = ctrl_valid & ~ctrl_ready;

        target_d  = target_q;
        limit_d   = limit_q;
        timeout_d = timeout_q;
        terr_d    = timeout_err;
        uerr_d    = underflow_err;

        issued_d    = hs ? issued_blocks + CNT_ONE : issued_blocks;
        completed_d = dout_finish ? completed_blocks + CNT_ONE
                                  : completed_blocks;

        // A handshake and a finish in the same cycle cancel out.
        inflight_d = in_flight;
        if (hs && !dout_finish) begin
            inflight_d = in_flight + CR_ONE;
        end else if (!hs && dout_finish) begin
            if (in_flight == '0) begin
                uerr_d = 1'b1;
            end else begin
                inflight_d = in_flight - CR_ONE;
            end
        end

        cycles_d = run_cycles;
        if (is_busy && (run_cycles != '1)) begin
            cycles_d = run_cycles + CNT_ONE;
        end

        // Watchdog measures idle time: any progress on either side restarts it.
        wd_d = wd_q;
        if (is_busy) begin
            if (hs || dout_finish) begin
                wd_d = '0;
            end else if (wd_q != '1) begin
                wd_d = wd_q + TO_ONE;
            end
        end
        expire = is_busy && (timeout_q != '0) && (wd_d == timeout_q);

        can_issue = (issued_d < target_q) && (inflight_d < limit_q);

        state_d = state_q;
        cv_d    = pending;

        case (state_q)
            ST_RUN: begin
                if (expire) begin
                    state_d = ST_DONE;
                end else if (abort || (issued_d == target_q)) begin
                    state_d = ST_DRAIN;
                end else begin
                    cv_d = pending | can_issue;
                end
            end
            ST_DRAIN: begin
                if (expire) begin
                    state_d = ST_DONE;
                end else if ((inflight_d == '0) && !pending) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE: a start launches a new run.  The first
                // beat is raised one cycle after busy rises.
                if (start) begin
                    target_d    = target_blocks;
                    limit_d     = (max_in_flight == '0) ? CR_ONE
                                                        : max_in_flight;
                    timeout_d   = timeout_cycles;
                    issued_d    = '0;
                    completed_d = '0;
                    inflight_d  = '0;
                    cycles_d    = '0;
                    wd_d        = '0;
                    terr_d      = 1'b0;
                    uerr_d      = 1'b0;
                    cv_d        = 1'b0;
                    state_d     = (target_blocks == '0) ? ST_DONE : ST_RUN;
                end
            end
        endcase

        // Watchdog expiry withdraws any pending beat and ends the run.
        if (expire) begin
            cv_d   = 1'b0;
            terr_d = 1'b1;
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            target_q         <= '0;
            limit_q          <= '0;
            timeout_q        <= '0;
            wd_q             <= '0;
            ctrl_valid       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            timeout_err      <= 1'b0;
            underflow_err    <= 1'b0;
            issued_blocks    <= '0;
            completed_blocks <= '0;
            in_flight        <= '0;
            run_cycles       <= '0;
        end else begin
            state_q          <= state_d;
            target_q         <= target_d;
            limit_q          <= limit_d;
            timeout_q        <= timeout_d;
            wd_q             <= wd_d;
            ctrl_valid       <= cv_d;
            busy             <= busy_d;
            done             <= done_d;
            timeout_err      <= terr_d;
            underflow_err    <= uerr_d;
            issued_blocks    <= issued_d;
            completed_blocks <= completed_d;
            in_flight        <= inflight_d;
            run_cycles       <= cycles_d;
        end
    end

endmodule
